dpu_feeder: RTL and testbench



---
 rtl/dpu_feeder_pkg.sv | 25 ++
 rtl/dpu_pipe_reg.sv | 31 +++
 rtl/dpu_feeder.sv | 103 ++++++++++
 tb/tb_dpu_feeder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dpu_feeder_pkg.sv
// Shared widths, the output group payload and the weight nibble selector.
package dpu_feeder_pkg;

    localparam int FP16_W     = 16;
    localparam int INT4_W     = 4;
    localparam int DPU_LANES  = 4;
    localparam int ACT_BEAT_W = 64;
    localparam int WT_BEAT_W  = 32;

    // One operand group toward the DPU; last closes a dot product
    typedef struct packed {
        logic                                 last;
        logic [DPU_LANES-1:0][FP16_W-1:0]     fp16;
        logic [DPU_LANES-1:0][INT4_W-1:0]     int4;
    } dpu_grp_t;

    localparam int GRP_W = $bits(dpu_grp_t);

    // Pick signed int4 nibble idx (0..7) out of a weight beat, bits untouched
    function automatic logic [INT4_W-1:0] wt_nibble(input logic [WT_BEAT_W-1:0] word,
                                                    input logic [2:0]           idx);
        return word[{idx, 2'b00} +: INT4_W];
    endfunction

endpackage

// File: rtl/dpu_pipe_reg.sv
// One-entry valid/ready register; accepts a new entry whenever it is
// empty or its current entry leaves in the same cycle.
module dpu_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // Load on handshake, drop valid once the entry is consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dpu_feeder.sv
// Pairs each half of an 8 x int4 weight beat with one 4 x fp16 activation
// beat and issues one operand group per cycle, tagging the last group of
// every K_GROUPS-long dot product.
module dpu_feeder
    import dpu_feeder_pkg::*;
#(
    parameter int K_GROUPS = 16,
    parameter int CNT_W    = $clog2(K_GROUPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  act_valid,
    output logic                  act_ready,
    input  logic [ACT_BEAT_W-1:0] act_data,
    input  logic                  wt_valid,
    output logic                  wt_ready,
    input  logic [WT_BEAT_W-1:0]  wt_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FP16_W-1:0]     out_fp16_0,
    output logic [FP16_W-1:0]     out_fp16_1,
    output logic [FP16_W-1:0]     out_fp16_2,
    output logic [FP16_W-1:0]     out_fp16_3,
    output logic [INT4_W-1:0]     out_int4_0,
    output logic [INT4_W-1:0]     out_int4_1,
    output logic [INT4_W-1:0]     out_int4_2,
    output logic [INT4_W-1:0]     out_int4_3,
    output logic                  out_last,
    output logic [CNT_W-1:0]      grp_cnt
);

    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(K_GROUPS - 1);

    logic [WT_BEAT_W-1:0] wt_buf;
    logic                 wt_full;
    logic                 h;
    logic                 out_free;
    logic                 act_fire;
    logic                 wt_fire;
    dpu_grp_t             grp_next;
    dpu_grp_t             grp_q;

    // act_ready never looks at act_valid/wt_valid, so no loop through the sources
    assign act_ready = wt_full && out_free;
    assign act_fire  = act_valid && act_ready;
    // A new weight may land in the cycle the second half is consumed: no bubble
    assign wt_ready  = !wt_full || (act_fire && h);
    assign wt_fire   = wt_valid && wt_ready;

    // Build the next group from the activation beat and the current weight half
    always_comb begin
        grp_next      = '0;
        grp_next.last = (grp_cnt == LAST_GRP);
        for (int n = 0; n < DPU_LANES; n++) begin
            grp_next.fp16[n] = act_data[n*FP16_W +: FP16_W];
            grp_next.int4[n] = wt_nibble(wt_buf, {h, 2'(n)});
        end
    end

    // Weight buffer, half select and group counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wt_buf  <= '0;
            wt_full <= 1'b0;
            h       <= 1'b0;
            grp_cnt <= '0;
        end else begin
            if (wt_fire) begin
                wt_buf  <= wt_data;
                wt_full <= 1'b1;
                h       <= 1'b0;
            end else if (act_fire) begin
                h <= ~h;
                if (h)
                    wt_full <= 1'b0;
            end
            if (act_fire)
                grp_cnt <= (grp_cnt == LAST_GRP) ? '0 : grp_cnt + 1'b1;
        end
    end

    dpu_pipe_reg #(.W(GRP_W)) u_out (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (act_fire),
        .in_ready  (out_free),
        .in_data   (grp_next),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (grp_q)
    );

    assign out_last   = grp_q.last;
    assign out_fp16_0 = grp_q.fp16[0];
    assign out_fp16_1 = grp_q.fp16[1];
    assign out_fp16_2 = grp_q.fp16[2];
    assign out_fp16_3 = grp_q.fp16[3];
    assign out_int4_0 = grp_q.int4[0];
    assign out_int4_1 = grp_q.int4[1];
    assign out_int4_2 = grp_q.int4[2];
    assign out_int4_3 = grp_q.int4[3];

endmodule

// File: tb/tb_dpu_feeder.sv
// Directed bench for dpu_feeder: pairing, streaming, back-pressure,
// weight starvation, mid-stream reset and same-cycle weight refill.
module tb_dpu_feeder;

    localparam int K = 16;
    localparam int NG = 2 * K;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        act_valid = 1'b0;
    logic        act_ready;
    logic [63:0] act_data = '0;
    logic        wt_valid = 1'b0;
    logic        wt_ready;
    logic [31:0] wt_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_fp16_0, out_fp16_1, out_fp16_2, out_fp16_3;
    logic [3:0]  out_int4_0, out_int4_1, out_int4_2, out_int4_3;
    logic        out_last;
    logic [3:0]  grp_cnt;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] wword [K];

    dpu_feeder #(.K_GROUPS(K)) dut (
        .clk(clk), .rst(rst),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fp16_0(out_fp16_0), .out_fp16_1(out_fp16_1),
        .out_fp16_2(out_fp16_2), .out_fp16_3(out_fp16_3),
        .out_int4_0(out_int4_0), .out_int4_1(out_int4_1),
        .out_int4_2(out_int4_2), .out_int4_3(out_int4_3),
        .out_last(out_last), .grp_cnt(grp_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [80:0] out_vec();
        return {out_last, out_fp16_3, out_fp16_2, out_fp16_1, out_fp16_0,
                out_int4_3, out_int4_2, out_int4_1, out_int4_0};
    endfunction

    function automatic logic [63:0] abeat(input int i);
        logic [63:0] b;
        for (int n = 0; n < 4; n++)
            b[16*n +: 16] = 16'(i * 256 + n * 16 + 1);
        return b;
    endfunction

    // Expected group g of the stream: beat g, weight word g/2, half g%2
    function automatic logic [80:0] exp_grp(input int g);
        logic [63:0] b;
        logic [31:0] w;
        int          o;
        b = abeat(g);
        w = wword[g / 2];
        o = (g % 2) * 16;
        return {(g % K) == K - 1, b[63:48], b[47:32], b[31:16], b[15:0],
                w[o+12 +: 4], w[o+8 +: 4], w[o+4 +: 4], w[o +: 4]};
    endfunction

    task automatic do_reset();
        act_valid = 1'b0;
        wt_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Stream NG activations and K weights, optionally stalling the output 5 cycles
    task automatic run_stream(input string tag, input int bp_at);
        int na = 0, nw = 0, ng = 0, nlast = 0, first_v = -1, last_v = -1;
        logic af, wf, mfull, mh;
        mfull = 1'b0;
        mh    = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 300 && ng < NG; cyc++) begin
            act_valid = (na < NG);
            act_data  = abeat(na);
            wt_valid  = (nw < K);
            wt_data   = wword[nw % K];
            out_ready = !(bp_at >= 0 && cyc >= bp_at && cyc < bp_at + 5);
            @(negedge clk);
            chk({tag, " grp_cnt"}, grp_cnt, na % K);
            if (out_valid) begin
                chk({tag, " group"}, out_vec(), exp_grp(ng));
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                if (out_ready) begin
                    nlast += out_last;
                    ng++;
                end
            end
            if (!out_ready) begin
                chk({tag, " bp act_ready"}, act_ready, 1'b0);
                chk({tag, " bp wt_ready"}, wt_ready, !mfull);
            end
            af = act_valid && act_ready;
            wf = wt_valid && wt_ready;
            if (wf) begin
                mfull = 1'b1;
                mh    = 1'b0;
            end else if (af) begin
                if (mh) mfull = 1'b0;
                mh = !mh;
            end
            tick();
            na += af;
            nw += wf;
        end
        act_valid = 1'b0;
        wt_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, " groups seen"}, ng, NG);
        chk({tag, " last count"}, nlast, 2);
        chk({tag, " valid span"}, last_v - first_v + 1, (bp_at >= 0) ? NG + 5 : NG);
        chk({tag, " end grp_cnt"}, grp_cnt, 0);
    endtask

    initial begin
        for (int j = 0; j < K; j++) wword[j] = $urandom;

        // Reset state
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst outputs", out_vec(), 0);
        chk("rst grp_cnt", grp_cnt, 0);
        chk("rst act_ready", act_ready, 0);
        chk("rst wt_ready", wt_ready, 1);
        tick();
        rst = 1'b0;

        // Starvation: activation waiting, no weight
        act_valid = 1'b1;
        act_data  = {16'h3333, 16'h2222, 16'h1111, 16'h3C00};
        tick();
        tick();
        chk("starve act_ready", act_ready, 0);
        chk("starve out_valid", out_valid, 0);

        // Basic pairing
        wt_valid = 1'b1;
        wt_data  = 32'h87654321;
        chk("wt empty act_ready", act_ready, 0);
        chk("wt empty wt_ready", wt_ready, 1);
        tick();
        wt_valid = 1'b0;
        chk("loaded act_ready", act_ready, 1);
        chk("loaded out_valid", out_valid, 0);
        tick();
        chk("g0 valid", out_valid, 1);
        chk("g0 data", out_vec(), {1'b0, 16'h3333, 16'h2222, 16'h1111, 16'h3C00, 16'h4321});
        chk("g0 grp_cnt", grp_cnt, 1);
        // Second half and refill weight together
        act_data = {16'h6666, 16'h5555, 16'h4444, 16'h3C00};
        wt_valid = 1'b1;
        wt_data  = 32'h0FEDCBA9;
        chk("refill wt_ready", wt_ready, 1);
        tick();
        wt_valid = 1'b0;
        chk("g1 data", out_vec(), {1'b0, 16'h6666, 16'h5555, 16'h4444, 16'h3C00, 16'h8765});
        chk("refill act_ready", act_ready, 1);
        act_data = {16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h3C00};
        tick();
        act_valid = 1'b0;
        chk("g2 data", out_vec(), {1'b0, 16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h3C00, 16'hCBA9});
        tick();
        chk("drain out_valid", out_valid, 0);
        chk("drain grp_cnt", grp_cnt, 3);

        // Reset mid dot product (h=1, weight buffered), asserted between edges
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst outputs", out_vec(), 0);
        chk("mid rst grp_cnt", grp_cnt, 0);
        chk("mid rst wt_ready", wt_ready, 1);
        chk("mid rst act_ready", act_ready, 0);
        tick();
        rst = 1'b0;
        wt_valid = 1'b1;
        wt_data  = 32'hFEDCBA98;
        tick();
        wt_valid  = 1'b0;
        act_valid = 1'b1;
        act_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        tick();
        act_valid = 1'b0;
        chk("post rst group", out_vec(), {1'b0, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'hBA98});

        run_stream("stream", -1);
        run_stream("bp", 10);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
